// File: rtl/icache_axi_refill.sv
// icache_axi_refill: read-only set-associative I-cache, AXI4 INCR line refill.
// Define ICACHE_PERF_COUNTERS_EN to build the hit/miss event counters.
module icache_axi_refill #(
    parameter int LINE_BYTES     = 64,
    parameter int SETS           = 64,
    parameter int WAYS           = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int INSTR_WIDTH    = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [INSTR_WIDTH-1:0]    resp_data,
    output logic                      resp_error,
    input  logic                      flush,
    input  logic                      invalidate_all,
    input  logic                      data_cache_reading,
    output logic                      instruction_cache_reading,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    output logic [31:0]               perf_hits,
    output logic [31:0]               perf_misses
);

    localparam int OFF_W    = $clog2(LINE_BYTES);
    localparam int IDX_BITS = $clog2(SETS);
    localparam int IDX_W    = (SETS > 1) ? IDX_BITS : 1;
    localparam int TAG_W    = ADDR_WIDTH - OFF_W - IDX_BITS;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE_W   = LINE_BYTES * 8;
    localparam int BEATS    = LINE_W / AXI_DATA_WIDTH;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORDS    = LINE_W / INSTR_WIDTH;
    localparam int WSEL_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [2:0] AR_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));
    localparam logic [7:0] AR_LEN  = 8'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_REFILL,
        S_RESPOND,
        S_INVAL
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    first_q, first_d;
    logic                    flushed_q, flushed_d;
    logic                    err_q, err_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic [INSTR_WIDTH-1:0]  rdata_q, rdata_d;
    logic                    rerr_q, rerr_d;

    logic [LINE_W-1:0]       data_mem [SETS][WAYS];
    logic [TAG_W-1:0]        tag_mem  [SETS][WAYS];
    logic [WAYS-1:0]         valid_q  [SETS];
    logic [WAY_W-1:0]        rr_q     [SETS];

    logic [IDX_W-1:0]        idx;
    logic [TAG_W-1:0]        tag;
    logic [WSEL_W-1:0]       wsel;
    logic                    hit;
    logic [WAY_W-1:0]        hit_way;
    logic [LINE_W-1:0]       hit_line;
    logic                    has_inv;
    logic [WAY_W-1:0]        victim;
    logic                    rbeat;
    logic                    beat_err;
    logic                    err_fin;
    logic                    fill_done;
    logic                    install;

    assign idx  = IDX_W'((addr_q >> OFF_W) & ADDR_WIDTH'(SETS - 1));
    assign tag  = TAG_W'(addr_q >> (OFF_W + IDX_BITS));
    assign wsel = WSEL_W'((addr_q >> 2) & ADDR_WIDTH'(WORDS - 1));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_mem[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_line = data_mem[idx][hit_way];

    // Descending scan leaves the lowest-index invalid way selected.
    always_comb begin
        has_inv = 1'b0;
        victim  = rr_q[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                has_inv = 1'b1;
                victim  = WAY_W'(w);
            end
        end
    end

    assign rbeat     = m_axi_rvalid && m_axi_rready;
    assign beat_err  = (m_axi_rresp != 2'b00) ||
                       (m_axi_rlast != (beat_q == BEAT_W'(BEATS - 1)));
    assign err_fin   = err_q || beat_err;
    assign fill_done = rbeat && m_axi_rlast;
    assign install   = fill_done && !err_fin;

    always_comb begin
        line_d = line_q;
        if (rbeat) begin
            line_d[int'(beat_q) * AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = m_axi_rdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        first_d   = first_q;
        flushed_d = flushed_q;
        err_d     = err_q;
        beat_d    = beat_q;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;
        case (state_q)
            S_IDLE: begin
                if (invalidate_all) begin
                    state_d = S_INVAL;
                end else if (req_valid) begin
                    addr_d    = req_addr;
                    first_d   = 1'b1;
                    flushed_d = 1'b0;
                    state_d   = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                first_d = 1'b0;
                if (flush) begin
                    state_d = S_IDLE;
                end else if (hit) begin
                    rdata_d = hit_line[int'(wsel) * INSTR_WIDTH +: INSTR_WIDTH];
                    rerr_d  = 1'b0;
                    state_d = S_RESPOND;
                end else if (!data_cache_reading) begin
                    err_d   = 1'b0;
                    beat_d  = '0;
                    state_d = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                // AR cannot be withdrawn once raised; a flush here only mutes the response.
                if (flush) flushed_d = 1'b1;
                if (m_axi_arready) state_d = S_REFILL;
            end
            S_REFILL: begin
                if (flush) flushed_d = 1'b1;
                if (rbeat) begin
                    err_d  = err_fin;
                    beat_d = beat_q + BEAT_W'(1);
                end
                if (fill_done) begin
                    rdata_d = line_d[int'(wsel) * INSTR_WIDTH +: INSTR_WIDTH];
                    rerr_d  = err_fin;
                    state_d = (flushed_q || flush) ? S_IDLE : S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (flush || resp_ready) state_d = S_IDLE;
            end
            S_INVAL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            first_q   <= 1'b0;
            flushed_q <= 1'b0;
            err_q     <= 1'b0;
            beat_q    <= '0;
            line_q    <= '0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            first_q   <= first_d;
            flushed_q <= flushed_d;
            err_q     <= err_d;
            beat_q    <= beat_d;
            line_q    <= line_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (state_q == S_INVAL) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (install) begin
            valid_q[idx][victim] <= 1'b1;
            if (WAYS > 1 && !has_inv) rr_q[idx] <= rr_q[idx] + WAY_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (install) begin
            data_mem[idx][victim] <= line_d;
            tag_mem[idx][victim]  <= tag;
        end
    end

    assign req_ready     = (state_q == S_IDLE) && !invalidate_all;
    assign resp_valid    = (state_q == S_RESPOND);
    assign resp_data     = rdata_q;
    assign resp_error    = rerr_q;
    assign m_axi_arvalid = (state_q == S_MISS_REQ);
    assign m_axi_araddr  = m_axi_arvalid ? (addr_q & ~ADDR_WIDTH'(LINE_BYTES - 1)) : '0;
    assign m_axi_arlen   = m_axi_arvalid ? AR_LEN : 8'd0;
    assign m_axi_arsize  = m_axi_arvalid ? AR_SIZE : 3'd0;
    assign m_axi_arburst = m_axi_arvalid ? 2'b01 : 2'b00;
    assign m_axi_rready  = (state_q == S_REFILL);
    assign instruction_cache_reading = (state_q == S_MISS_REQ) || (state_q == S_REFILL);

`ifdef ICACHE_PERF_COUNTERS_EN
    logic [31:0] hits_q, misses_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state_q == S_LOOKUP && first_q) begin
            if (hit) hits_q <= hits_q + 32'd1;
            else     misses_q <= misses_q + 32'd1;
        end
    end

    assign perf_hits   = hits_q;
    assign perf_misses = misses_q;
`else
    logic unused_first;
    assign unused_first = first_q;
    assign perf_hits    = '0;
    assign perf_misses  = '0;
`endif

endmodule

// File: tb/tb_icache_axi_refill.sv
// tb_icache_axi_refill: scoreboard bench with a behavioural AXI read slave.
// Covers hit/miss timing, round-robin eviction, flush, RRESP error, arbitration.
module tb_icache_axi_refill;

    localparam int K_HIT   = 0;
    localparam int K_MISS  = 1;
    localparam int K_ERR   = 2;
    localparam int K_FLUSH = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [63:0] req_addr;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic        resp_error;
    logic        flush, invalidate_all, dcr, icr;
    logic        arvalid, arready;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [31:0] perf_hits, perf_misses;

    always #5 clk = ~clk;

    icache_axi_refill dut (
        .clock                     (clk),
        .reset_n                   (rst_n),
        .req_valid                 (req_valid),
        .req_ready                 (req_ready),
        .req_addr                  (req_addr),
        .resp_valid                (resp_valid),
        .resp_ready                (resp_ready),
        .resp_data                 (resp_data),
        .resp_error                (resp_error),
        .flush                     (flush),
        .invalidate_all            (invalidate_all),
        .data_cache_reading        (dcr),
        .instruction_cache_reading (icr),
        .m_axi_arvalid             (arvalid),
        .m_axi_arready             (arready),
        .m_axi_araddr              (araddr),
        .m_axi_arlen               (arlen),
        .m_axi_arsize              (arsize),
        .m_axi_arburst             (arburst),
        .m_axi_rvalid              (rvalid),
        .m_axi_rready              (rready),
        .m_axi_rdata               (rdata),
        .m_axi_rresp               (rresp),
        .m_axi_rlast               (rlast),
        .perf_hits                 (perf_hits),
        .perf_misses               (perf_misses)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          chk;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;
    int          ar_cnt, ar_base;
    int          err_beat = -1;
    int          flush_beat = -1;
    bit          slv_tmo;
    logic [63:0] cap_addr;
    logic [7:0]  cap_len;
    logic [2:0]  cap_size;
    logic [1:0]  cap_burst;
    longint      t_rlast, t_resp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] beat(input logic [63:0] base, input int k);
        logic [63:0] b;
        b = base + 64'(8 * k);
        return {word(b + 64'd4), word(b)};
    endfunction

    // AXI read slave: one outstanding burst, optional error/flush injection.
    initial begin
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        flush   = 1'b0;
        ar_cnt  = 0;
        slv_tmo = 1'b0;
        t_rlast = 0;
        forever begin
            @(negedge clk);
            if (rst_n && arvalid) begin
                ar_cnt++;
                cap_addr  = araddr;
                cap_len   = arlen;
                cap_size  = arsize;
                cap_burst = arburst;
                arready   = 1'b1;
                @(negedge clk);
                arready = 1'b0;
                for (int k = 0; k <= int'(cap_len); k++) begin
                    int n;
                    rvalid = 1'b1;
                    rdata  = beat(cap_addr, k);
                    rresp  = (k == err_beat) ? 2'b10 : 2'b00;
                    rlast  = (k == int'(cap_len));
                    flush  = (k == flush_beat);
                    n = 0;
                    while (!rready && n < 100) begin
                        @(negedge clk);
                        n++;
                    end
                    if (n >= 100) slv_tmo = 1'b1;
                    if (rlast) t_rlast = $time + 5;
                    @(negedge clk);
                end
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
                flush  = 1'b0;
            end
        end
    end

    task automatic issue(input logic [63:0] a, input int kind);
        int n;
        ar_base = ar_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("req_timeout", 0, 1);
        if (kind != K_FLUSH) sb.push_back('{word(a & ~64'h3), kind == K_ERR, kind != K_ERR});
        if (kind == K_HIT) exp_hits++;
        else exp_misses++;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic complete(input int kind, input int hold);
        int n, lat, seen;
        logic [31:0] d0;
        exp_t e;
        lat = 1;
        if (kind == K_FLUSH) begin
            seen = 0;
            n = 0;
            while (!req_ready && n < 200) begin
                if (resp_valid) seen++;
                @(negedge clk);
                n++;
            end
            check("flush_no_resp", 64'(seen), 0);
        end else begin
            n = 0;
            while (!resp_valid && n < 200) begin
                @(negedge clk);
                n++;
                lat++;
            end
            if (!resp_valid) begin
                check("resp_timeout", 0, 1);
            end else begin
                t_resp = $time;
                d0 = resp_data;
                if (hold > 0) begin
                    repeat (hold) @(negedge clk);
                    check("resp_hold", {resp_valid, resp_data}, {1'b1, d0});
                    resp_ready = 1'b1;
                end
                e = sb.pop_front();
                if (e.chk) check("resp_data", resp_data, e.data);
                check("resp_error", resp_error, e.err);
                if (kind == K_HIT) check("hit_latency", 64'(lat), 2);
                else check("miss_latency", 64'(t_resp - t_rlast), 5);
                @(negedge clk);
                check("back_to_idle", {resp_valid, req_ready}, 2'b01);
            end
        end
        check("ar_count", 64'(ar_cnt - ar_base), (kind == K_HIT) ? 0 : 1);
    endtask

    task automatic fetch(input logic [63:0] a, input int kind, input int hold);
        resp_ready = (hold == 0);
        issue(a, kind);
        complete(kind, hold);
        resp_ready = 1'b1;
    endtask

    task automatic check_perf();
`ifdef ICACHE_PERF_COUNTERS_EN
        check("perf_hits", perf_hits, 64'(exp_hits));
        check("perf_misses", perf_misses, 64'(exp_misses));
`else
        check("perf_hits", perf_hits, 0);
        check("perf_misses", perf_misses, 0);
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] set1 [6];
        int seq_i [18];
        int seq_k [18];
        int bad;
        seq_i = '{0, 1, 2, 3, 4, 1, 2, 3, 5, 2, 3, 4, 0, 3, 4, 5, 0, 2};
        seq_k = '{K_MISS, K_MISS, K_MISS, K_MISS, K_MISS, K_HIT, K_HIT, K_HIT, K_MISS,
                  K_HIT, K_HIT, K_HIT, K_MISS, K_HIT, K_HIT, K_HIT, K_HIT, K_MISS};
        for (int i = 0; i < 6; i++) set1[i] = 64'h1_0040 + 64'(i) * 64'h1000;

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        resp_ready = 1'b1;
        invalidate_all = 1'b0;
        dcr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp", {resp_valid, resp_error, resp_data}, 0);
        check("rst_axi_ctl", {arvalid, rready, icr}, 0);
        check("rst_ar_fields", {araddr, arlen, arsize, arburst}, 0);
        check_perf();

        // Cold miss, then hits on the same line.
        fetch(64'h1004, K_MISS, 0);
        check("araddr", cap_addr, 64'h1000);
        check("arlen", cap_len, 7);
        check("arsize", cap_size, 3);
        check("arburst", cap_burst, 1);
        fetch(64'h1004, K_HIT, 0);
        fetch(64'h1038, K_HIT, 3);

        // Round-robin replacement in set 1.
        for (int i = 0; i < 18; i++) fetch(set1[seq_i[i]], seq_k[i], 0);
        check_perf();

        // Flush mid-burst: line still installed, no response.
        flush_beat = 3;
        fetch(64'h2008, K_FLUSH, 0);
        flush_beat = -1;
        fetch(64'h2008, K_HIT, 0);

        // RRESP error on beat 5: nothing installed.
        err_beat = 5;
        fetch(64'h3010, K_ERR, 0);
        err_beat = -1;
        fetch(64'h3010, K_MISS, 0);
        fetch(64'h3010, K_HIT, 0);

        // Data cache owns the bus for 10 cycles.
        dcr = 1'b1;
        issue(64'h4020, K_MISS);
        bad = 0;
        repeat (10) begin
            if (arvalid || icr) bad++;
            @(negedge clk);
        end
        check("dcr_stall", 64'(bad), 0);
        dcr = 1'b0;
        complete(K_MISS, 0);
        check_perf();

        // Bulk invalidate wins over a simultaneous request.
        @(negedge clk);
        invalidate_all = 1'b1;
        req_valid = 1'b1;
        req_addr = 64'h1004;
        #1;
        check("inval_req_ready", req_ready, 0);
        @(negedge clk);
        invalidate_all = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("inval_quiet", {resp_valid, arvalid, req_ready}, 3'b001);
        fetch(64'h1004, K_MISS, 0);
        fetch(set1[4], K_MISS, 0);
        fetch(64'h2008, K_MISS, 0);

        check("slave_timeout", slv_tmo, 0);
        check("sb_empty", 64'(sb.size()), 0);
        check_perf();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
